// File: rtl/npu_act_pkg.sv
// npu_act_pkg
//   Shared types and default widths for the NPU activation stage.
//   act_mode_e       : per-beat activation selector (IDENT, RELU, LEAKY, CLIP)
//   DEF_*            : default parameter values used by activation_unit
//   zero_cnt_width() : bits needed to hold a count of 0..lanes
package npu_act_pkg;

  typedef enum logic [1:0] {
    ACT_IDENT = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2,
    ACT_CLIP  = 2'd3
  } act_mode_e;

  localparam int DEF_DATA_WIDTH  = 22;
  localparam int DEF_OUT_WIDTH   = 16;
  localparam int DEF_LANES       = 4;
  localparam int DEF_LEAKY_SHIFT = 3;
  localparam int DEF_SHIFT_W     = 5;
  localparam int DEF_CNT_WIDTH   = 32;

  function automatic int zero_cnt_width(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/act_lane_datapath.sv
// act_lane_datapath
//   Purely combinational datapath for one lane. The two halves are used on
//   opposite sides of the S1/S2 register boundary in activation_unit.
//   Activate half:
//     mode     in  activation selector (act_mode_e encoding)
//     clip_max in  CLIP upper bound; MSB set means "largest positive value"
//     x        in  signed input sample
//     act      out signed activated sample (registered into S1 by the parent)
//   Requantise half:
//     act_in   in  activated sample from the S1 register
//     shift    in  requantisation right shift carried with the beat
//     q        out rounded (half-up), shifted and saturated output sample
module act_lane_datapath
  import npu_act_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int LEAKY_SHIFT = DEF_LEAKY_SHIFT,
  parameter int SHIFT_W     = DEF_SHIFT_W
) (
  input  logic        [1:0]            mode,
  input  logic        [DATA_WIDTH-1:0] clip_max,
  input  logic signed [DATA_WIDTH-1:0] x,
  output logic signed [DATA_WIDTH-1:0] act,
  input  logic signed [DATA_WIDTH-1:0] act_in,
  input  logic        [SHIFT_W-1:0]    shift,
  output logic signed [OUT_WIDTH-1:0]  q
);

  // Saturation bounds expressed in the DATA_WIDTH+1 requant domain.
  localparam logic signed [DATA_WIDTH:0] OUT_MAX =
    {{(DATA_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [DATA_WIDTH:0] OUT_MIN =
    {{(DATA_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  logic [DATA_WIDTH-1:0] clip_eff;

  // Activation
  always_comb begin
    // A bound with the sign bit set would be negative; treat it as +max.
    clip_eff = clip_max[DATA_WIDTH-1] ? {1'b0, {(DATA_WIDTH - 1){1'b1}}} : clip_max;
    act      = x;
    case (act_mode_e'(mode))
      ACT_IDENT: act = x;
      ACT_RELU:  act = x[DATA_WIDTH-1] ? '0 : x;
      ACT_LEAKY: act = x[DATA_WIDTH-1] ? (x >>> LEAKY_SHIFT) : x;
      ACT_CLIP: begin
        if (x[DATA_WIDTH-1])
          act = '0;
        else if (DATA_WIDTH'(x) > clip_eff)
          act = clip_eff;
        else
          act = x;
      end
      default:   act = x;
    endcase
  end

  // Requantisation
  logic        [SHIFT_W-1:0]  s_eff;
  logic signed [DATA_WIDTH:0] ext;
  logic signed [DATA_WIDTH:0] rnd;
  logic signed [DATA_WIDTH:0] sum;
  logic signed [DATA_WIDTH:0] shr;

  always_comb begin
    if (int'(shift) > DATA_WIDTH - 1)
      s_eff = SHIFT_W'(DATA_WIDTH - 1);
    else
      s_eff = shift;

    // One guard bit keeps the rounding add from overflowing.
    ext = {act_in[DATA_WIDTH-1], act_in};
    rnd = '0;
    if (s_eff != '0)
      rnd = (DATA_WIDTH + 1)'(1) << (s_eff - SHIFT_W'(1));
    sum = ext + rnd;
    shr = sum >>> s_eff;

    if (shr > OUT_MAX)
      q = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    else if (shr < OUT_MIN)
      q = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
    else
      q = shr[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/activation_unit.sv
// activation_unit
//   Two-stage, LANES-wide activation + requantisation pipeline.
//   S1 registers the activated samples together with the beat's shift and
//   last flag; S2 registers the requantised result and drives out_* directly.
//
//   Handshake: a beat moves on a channel when valid && ready are both high at
//   a rising clk edge. Once out_valid is raised, out_data/out_last stay stable
//   until out_ready accepts the beat. in_ready depends only on pipeline state
//   (never on in_valid) and is low while rst is high.
//
//   Ports:
//     clk, rst                clock, async active-high reset
//     cfg_mode/cfg_clip_max   sampled with each accepted beat
//     cfg_shift               sampled on acceptance and carried to S2
//     in_valid/in_ready/in_data/in_last     upstream beat channel
//     out_valid/out_ready/out_data/out_last downstream beat channel
//     stats_clr               synchronous clear of zero_count (wins over count)
//     zero_count              saturating count of zero output lanes delivered
module activation_unit
  import npu_act_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int LANES       = DEF_LANES,
  parameter int LEAKY_SHIFT = DEF_LEAKY_SHIFT,
  parameter int SHIFT_W     = DEF_SHIFT_W,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    cfg_mode,
  input  logic [SHIFT_W-1:0]            cfg_shift,
  input  logic [DATA_WIDTH-1:0]         cfg_clip_max,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*OUT_WIDTH-1:0]    out_data,
  output logic                          out_last,
  input  logic                          stats_clr,
  output logic [CNT_WIDTH-1:0]          zero_count
);

  localparam int ZW = zero_cnt_width(LANES);

  logic s1_v;
  logic s2_v;
  logic s1_adv;
  logic s2_adv;

  logic signed [DATA_WIDTH-1:0] act_next [LANES];
  logic signed [DATA_WIDTH-1:0] s1_act   [LANES];
  logic signed [OUT_WIDTH-1:0]  q_next   [LANES];
  logic        [SHIFT_W-1:0]    s1_shift;
  logic                         s1_last;

  assign s2_adv    = !s2_v || out_ready;
  assign s1_adv    = !s1_v || s2_adv;
  assign in_ready  = s1_adv && !rst;
  assign out_valid = s2_v;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    act_lane_datapath #(
      .DATA_WIDTH  (DATA_WIDTH),
      .OUT_WIDTH   (OUT_WIDTH),
      .LEAKY_SHIFT (LEAKY_SHIFT),
      .SHIFT_W     (SHIFT_W)
    ) u_lane (
      .mode     (cfg_mode),
      .clip_max (cfg_clip_max),
      .x        (in_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .act      (act_next[g]),
      .act_in   (s1_act[g]),
      .shift    (s1_shift),
      .q        (q_next[g])
    );
  end

  // S1: activation register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v     <= 1'b0;
      s1_shift <= '0;
      s1_last  <= 1'b0;
      for (int i = 0; i < LANES; i++) s1_act[i] <= '0;
    end else if (s1_adv) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_shift <= cfg_shift;
        s1_last  <= in_last;
        for (int i = 0; i < LANES; i++) s1_act[i] <= act_next[i];
      end
    end
  end

  // S2: requantised output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v     <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        out_last <= s1_last;
        for (int i = 0; i < LANES; i++) out_data[i*OUT_WIDTH +: OUT_WIDTH] <= q_next[i];
      end
    end
  end

  // Zero-lane statistics
  logic [ZW-1:0]        zero_lanes;
  logic [CNT_WIDTH:0]   cnt_sum;

  always_comb begin
    zero_lanes = '0;
    for (int i = 0; i < LANES; i++)
      if (out_data[i*OUT_WIDTH +: OUT_WIDTH] == '0) zero_lanes = zero_lanes + ZW'(1);
    cnt_sum = {1'b0, zero_count} + (CNT_WIDTH + 1)'(zero_lanes);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      zero_count <= '0;
    else if (stats_clr)
      zero_count <= '0;
    else if (out_valid && out_ready)
      zero_count <= cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
  end

endmodule
